// File: rtl/fetch_decode_unit_if.sv
// Fetch/decode bus bundle.
// Groups the instruction-memory read port and the decoded-instruction
// valid/ready handshake toward the execute stage.
//   master : fetch/decode side (drives mem_addr/mem_rd and the dec_* bundle)
//   slave  : memory + execute side (drives mem_rdata and dec_ready)
interface fetch_decode_unit_if;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       dec_valid;
  logic       dec_ready;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_src;
  logic [1:0] dec_mem_op;
  logic [3:0] dec_flag_src;
  logic [7:0] dec_dst;
  logic [7:0] dec_operand;
  logic       dec_wb;

  modport master (
    output mem_addr, mem_rd,
    input  mem_rdata,
    output dec_valid,
    input  dec_ready,
    output dec_alu_op, dec_src, dec_mem_op, dec_flag_src, dec_dst, dec_operand, dec_wb
  );

  modport slave (
    input  mem_addr, mem_rd,
    output mem_rdata,
    input  dec_valid,
    output dec_ready,
    input  dec_alu_op, dec_src, dec_mem_op, dec_flag_src, dec_dst, dec_operand, dec_wb
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode unit for a 3-byte instruction format (opcode, dst, operand).
// Fetches the three bytes over a one-cycle-latency memory port, decodes the
// opcode into ALU/source/memory/flag/writeback fields and offers the bundle
// to the execute stage with a valid/ready handshake.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_decode_unit_if.master (memory read port + dec_* bundle)
//   pc       : address of the next opcode byte
//   halted   : HALT reached (or illegal opcode trapped)
//   illegal  : illegal opcode trapped
// Configuration macro: Z8_ILLEGAL_OP_TRAP_EN -- when defined, opcodes above
// HALT trap (illegal=1, halted=1); otherwise they behave as NOP and illegal=0.
module fetch_decode_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_decode_unit_if.master   bus,
  output logic [7:0]            pc,
  output logic                  halted,
  output logic                  illegal
);

  typedef enum logic [2:0] {F_OP, F_DST, F_SRC, DECODE, ISSUE, HALT} state_t;

  typedef enum logic [7:0] {
    OP_NOP = 8'h00, OP_LDM = 8'h01, OP_LDR = 8'h02, OP_LDD = 8'h03,
    OP_STR = 8'h04, OP_STD = 8'h05, OP_ADR = 8'h06, OP_SBR = 8'h07,
    OP_ANR = 8'h08, OP_ORR = 8'h09, OP_XOR = 8'h0A, OP_ADD = 8'h0B,
    OP_SBD = 8'h0C, OP_AND = 8'h0D, OP_ORD = 8'h0E, OP_XOD = 8'h0F,
    OP_CPR = 8'h10, OP_CPD = 8'h11, OP_HALT = 8'h12
  } opcodes_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_AND = 4'd3,
    ALU_OR  = 4'd4, ALU_XOR = 4'd5, ALU_CMP = 4'd6
  } alu_ops_t;

  typedef enum logic [1:0] {SRC_VAL = 2'd0, SRC_REG = 2'd1, SRC_MEM = 2'd2} data_source_t;
  typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2} mem_ops_t;
  typedef enum logic [3:0] {FLAG_NONE = 4'd0, FLAG_ALU = 4'd1} flag_source_t;

  state_t       state, state_n;
  logic [7:0]   opcode_q, dst_q;
  alu_ops_t     alu_q, d_alu;
  data_source_t src_q, d_src;
  mem_ops_t     mem_q, d_mem;
  flag_source_t flag_q, d_flag;
  logic         wb_q, d_wb;
  logic [7:0]   dec_dst_q, dec_operand_q;
  logic         d_issue, d_halt;
`ifdef Z8_ILLEGAL_OP_TRAP_EN
  logic         d_trap, illegal_q;
`endif

  // Opcode decode from the latched opcode byte.
  always_comb begin
    d_alu   = ALU_NOP;
    d_src   = SRC_VAL;
    d_mem   = MEM_NOP;
    d_flag  = FLAG_NONE;
    d_wb    = 1'b0;
    d_issue = 1'b1;
    d_halt  = 1'b0;
`ifdef Z8_ILLEGAL_OP_TRAP_EN
    d_trap  = 1'b0;
`endif
    case (opcode_q)
      OP_NOP:  d_issue = 1'b0;
      OP_LDM:  begin d_src = SRC_MEM; d_mem = MEM_READ; d_wb = 1'b1; end
      OP_LDR:  begin d_src = SRC_REG; d_wb = 1'b1; end
      OP_LDD:  d_wb = 1'b1;
      OP_STR:  begin d_src = SRC_REG; d_mem = MEM_WRITE; end
      OP_STD:  d_mem = MEM_WRITE;
      OP_ADR:  begin d_alu = ALU_ADD; d_src = SRC_REG; d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_SBR:  begin d_alu = ALU_SUB; d_src = SRC_REG; d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_ANR:  begin d_alu = ALU_AND; d_src = SRC_REG; d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_ORR:  begin d_alu = ALU_OR;  d_src = SRC_REG; d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_XOR:  begin d_alu = ALU_XOR; d_src = SRC_REG; d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_ADD:  begin d_alu = ALU_ADD; d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_SBD:  begin d_alu = ALU_SUB; d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_AND:  begin d_alu = ALU_AND; d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_ORD:  begin d_alu = ALU_OR;  d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_XOD:  begin d_alu = ALU_XOR; d_flag = FLAG_ALU; d_wb = 1'b1; end
      OP_CPR:  begin d_alu = ALU_CMP; d_src = SRC_REG; d_flag = FLAG_ALU; end
      OP_CPD:  begin d_alu = ALU_CMP; d_flag = FLAG_ALU; end
      OP_HALT: begin d_issue = 1'b0; d_halt = 1'b1; end
      default: begin
        d_issue = 1'b0;
`ifdef Z8_ILLEGAL_OP_TRAP_EN
        d_halt  = 1'b1;
        d_trap  = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      F_OP:    state_n = F_DST;
      F_DST:   state_n = F_SRC;
      F_SRC:   state_n = DECODE;
      DECODE:  state_n = d_halt ? HALT : (d_issue ? ISSUE : F_OP);
      ISSUE:   if (bus.dec_ready) state_n = F_OP;
      HALT:    state_n = HALT;
      default: state_n = F_OP;
    endcase
  end

  // Strobes are masked while rst is high so nothing is fetched or offered
  // during the reset cycle regardless of the pre-reset state.
  always_comb begin
    bus.mem_rd   = 1'b0;
    bus.mem_addr = pc;
    case (state)
      F_OP:    bus.mem_rd = ~rst;
      F_DST:   begin bus.mem_rd = ~rst; bus.mem_addr = pc + 8'd1; end
      F_SRC:   begin bus.mem_rd = ~rst; bus.mem_addr = pc + 8'd2; end
      default: ;
    endcase
  end

  assign bus.dec_valid    = (state == ISSUE) && !rst;
  assign bus.dec_alu_op   = alu_q;
  assign bus.dec_src      = src_q;
  assign bus.dec_mem_op   = mem_q;
  assign bus.dec_flag_src = flag_q;
  assign bus.dec_wb       = wb_q;
  assign bus.dec_dst      = dec_dst_q;
  assign bus.dec_operand  = dec_operand_q;
  assign halted           = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= F_OP;
      pc            <= RESET_PC;
      opcode_q      <= '0;
      dst_q         <= '0;
      alu_q         <= ALU_NOP;
      src_q         <= SRC_VAL;
      mem_q         <= MEM_NOP;
      flag_q        <= FLAG_NONE;
      wb_q          <= 1'b0;
      dec_dst_q     <= '0;
      dec_operand_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        F_DST:  opcode_q <= bus.mem_rdata;
        F_SRC:  dst_q    <= bus.mem_rdata;
        // Operand byte is consumed straight off the bus into the bundle.
        DECODE: begin
          pc            <= pc + 8'd3;
          alu_q         <= d_alu;
          src_q         <= d_src;
          mem_q         <= d_mem;
          flag_q        <= d_flag;
          wb_q          <= d_wb;
          dec_dst_q     <= dst_q;
          dec_operand_q <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef Z8_ILLEGAL_OP_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (state == DECODE && d_trap)
      illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule
